window_3x3_serializer: RTL and testbench
========================================

Name: window_3x3_serializer

Overview:
- Upstream stage of the Gaussian blur kernel engine. Accepts a raster-scanned RGB pixel stream over AXI-Stream and keeps two line buffers plus a 3x3 column shift window.
- For every interior pixel, emits its 3x3 neighbourhood as 9 consecutive 24-bit beats. This is the 9-beat batch format the blur stage consumes.
- Border pixels (row 0, row H-1, column 0, column W-1) produce no window. Output is (IMG_WIDTH-2)x(IMG_HEIGHT-2) windows per frame.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=3)
- IMG_HEIGHT, 480, lines per frame (>=3)
- DATA_W, 24, pixel width {R[23:16],G[15:8],B[7:0]}, passed through untouched

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_W  input pixel
- s_axis_tvalid  in  1  input pixel valid
- s_axis_tuser  in  1  start-of-frame, marks pixel (0,0)
- s_axis_tready  out  1  stage accepts a pixel
- m_axis_tdata  out  DATA_W  window beat
- m_axis_tvalid  out  1  window beat valid
- m_axis_tuser  out  1  beat 0 of the frame's first window
- m_axis_tlast  out  1  beat 8 (last) of every window
- m_axis_tready  in  1  downstream accepts beat

Behaviour:
- Reset values: state=ACCEPT, s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, x=0, y=0, beat=0, window regs=0. Line buffer contents are not reset; the y<2 gating makes them don't-care.
- Counters: x is $clog2(IMG_WIDTH) bits, y is $clog2(IMG_HEIGHT) bits. Both give the position of the next input pixel.
  - On accept, x increments.
  - At x=W-1, x wraps to 0 and y increments.
  - At (W-1,H-1), both wrap to 0.
- Storage: two line buffers, lb_top and lb_mid, each IMG_WIDTH x DATA_W registers. They hold rows y-2 and y-1. The window is 3 rows x 3 cols of registers.
- Accept (s_axis_tvalid && s_axis_tready) of pixel P at (x,y):
  - Shift the window left by one column.
  - New right column is {lb_top[x], lb_mid[x], P}, read before write.
  - Write lb_top[x]<=lb_mid[x] and lb_mid[x]<=P.
- SOF resync: if s_axis_tuser=1 on an accepted pixel, that pixel is treated as (0,0) regardless of the counters. x becomes 1 and y becomes 0 afterwards.
- States:
  - ACCEPT: s_axis_tready=1, m_axis_tvalid=0. An accept with x>=2 and y>=2 (post-resync coordinates) moves to EMIT next cycle with beat=0. Otherwise stay in ACCEPT.
  - EMIT: s_axis_tready=0, m_axis_tvalid=1. The window is frozen.
    - m_axis_tdata = win[beat/3][beat%3], row-major: beat0=top-left, beat4=centre, beat8=bottom-right.
    - Each m_axis_tvalid && m_axis_tready advances beat.
    - A handshake at beat=8 returns to ACCEPT with beat=0.
- Outputs are registered and change only on clock edges. Data, tuser and tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- m_axis_tlast=1 only on beat 8.
- m_axis_tuser=1 only on beat 0 of the window whose completing pixel is (2,2), i.e. the window centred at (1,1).
- Latency and throughput:
  - Beat 0 of a window is valid on the cycle after the edge that accepted the completing pixel.
  - An interior-window pixel costs 1 accept cycle plus 9 emit cycles when there is no backpressure.
  - A non-window pixel costs 1 cycle.
- s_axis_tlast is not a port. Line length comes only from IMG_WIDTH.
- Reset asserted mid-EMIT aborts the window with no further beats. After release, the stream restarts expecting SOF/(0,0).

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4, pixels = {8'h0,y,x} in raster order, SOF on first, m_axis_tready=1 -> exactly 4 windows (36 beats).
   - Window 1: 000,001,002,100,101,102,200,201,202 (hex, low 12 bits); tuser on beat 0, tlast on beat 8.
   - Window 4 centre = 0x0202.
2. Same image, m_axis_tready toggled 1-0-0-1 pseudo-randomly -> identical beat sequence. tdata/tuser/tlast held while stalled. s_axis_tready=0 throughout every EMIT.
3. Two back-to-back 4x4 frames -> second frame's first window beat 0 = frame-2 pixel (0,0) with tuser=1. Total 8 windows. No window mixes frames.
4. SOF asserted on pixel 5 of a frame (mid-row 1) -> counters resync. No window emitted until resynced (2,2). The first window contains only post-SOF pixels.
5. rst_n pulsed low during beat 4 of window 2 -> m_axis_tvalid=0 immediately (async). s_axis_tready=1 after release. A fresh frame then yields 4 correct windows.
6. s_axis_tvalid gapped (1 pixel every 3 cycles) on a 5x3 image -> 3 windows with centres 0x0101, 0x0102, 0x0103.

Source files
------------

// File: rtl/window_3x3_serializer.sv
// -----------------------------------------------------------------------------
// window_3x3_serializer
//
// Upstream stage of the Gaussian blur engine. Takes a raster-scanned pixel
// stream, keeps the two previous lines in line buffers and a 3x3 column-shift
// window. For every interior pixel it emits the 3x3 neighbourhood as nine
// consecutive beats in row-major order:
// - beat 0 is top-left.
// - beat 4 is the centre.
// - beat 8 is bottom-right.
// Border pixels produce no window.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   input pixel {R,G,B}
//   s_axis_tvalid  input pixel valid
//   s_axis_tuser   start of frame, marks pixel (0,0)
//   s_axis_tready  stage accepts a pixel (low while a window is emitted)
//   m_axis_tdata   window beat
//   m_axis_tvalid  window beat valid
//   m_axis_tuser   beat 0 of the first window of a frame
//   m_axis_tlast   beat 8 of every window
//   m_axis_tready  downstream accepts the beat
// -----------------------------------------------------------------------------
module window_3x3_serializer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tuser,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_TWO     = XW'(2);
  localparam logic [YW-1:0] Y_TWO     = YW'(2);
  localparam logic [3:0]    BEAT_LAST = 4'd8;

  typedef enum logic {
    ACCEPT = 1'b0,
    EMIT   = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic [3:0]        beat_reg, beat_next;
  logic              first_reg, first_next;

  logic              s_tready_reg;
  logic              m_tvalid_reg, m_tvalid_next;
  logic [DATA_W-1:0] m_tdata_reg, m_tdata_next;
  logic              m_tuser_reg, m_tuser_next;
  logic              m_tlast_reg, m_tlast_next;

  logic              accept;
  logic [XW-1:0]     x_eff;
  logic [YW-1:0]     y_eff;
  logic              win_done;

  // Line buffers hold rows y-2 (top) and y-1 (mid). They are never reset:
  // no window is formed until two full lines have been written this frame.
  logic [DATA_W-1:0] lb_top [IMG_WIDTH];
  logic [DATA_W-1:0] lb_mid [IMG_WIDTH];

  // Incoming right-hand column, top to bottom, and the window as it will
  // look after this cycle (flattened row-major, index = row*3 + col).
  logic [DATA_W-1:0] col_new  [3];
  logic [DATA_W-1:0] win_next [9];

  assign accept = s_axis_tvalid && s_tready_reg;

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  assign x_eff = s_axis_tuser ? '0 : x_reg;
  assign y_eff = s_axis_tuser ? '0 : y_reg;

  // The accepted pixel completes an interior window once it sits at
  // column >= 2 of row >= 2.
  assign win_done = accept && (x_eff >= X_TWO) && (y_eff >= Y_TWO);

  // Read before write: the column uses the old line buffer contents.
  assign col_new[0] = lb_top[x_eff];
  assign col_new[1] = lb_mid[x_eff];
  assign col_new[2] = s_axis_tdata;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[x_eff] <= lb_mid[x_eff];
      lb_mid[x_eff] <= s_axis_tdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Window rows: each row shifts left on accept and takes its new right-hand
  // pixel from the incoming column. Nothing can be accepted during EMIT, so
  // the window stays frozen while its beats are sent.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_W-1:0] cell_reg  [3];
      logic [DATA_W-1:0] cell_next [3];

      always_comb begin
        cell_next[0] = cell_reg[0];
        cell_next[1] = cell_reg[1];
        cell_next[2] = cell_reg[2];
        if (accept) begin
          cell_next[0] = cell_reg[1];
          cell_next[1] = cell_reg[2];
          cell_next[2] = col_new[gi];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cell_reg[0] <= '0;
          cell_reg[1] <= '0;
          cell_reg[2] <= '0;
        end else begin
          cell_reg[0] <= cell_next[0];
          cell_reg[1] <= cell_next[1];
          cell_reg[2] <= cell_next[2];
        end
      end

      assign win_next[gi*3 + 0] = cell_next[0];
      assign win_next[gi*3 + 1] = cell_next[1];
      assign win_next[gi*3 + 2] = cell_next[2];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Position counters: they track the next input pixel.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (accept) begin
      if (x_eff == X_LAST) begin
        x_next = '0;
        y_next = (y_eff == Y_LAST) ? '0 : y_eff + YW'(1);
      end else begin
        x_next = x_eff + XW'(1);
        y_next = y_eff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    first_next = first_reg;
    case (state_reg)
      ACCEPT: begin
        if (win_done) begin
          state_next = EMIT;
          beat_next  = '0;
          // The window centred at (1,1) is the first window of the frame.
          first_next = (x_eff == X_TWO) && (y_eff == Y_TWO);
        end
      end
      EMIT: begin
        if (m_tvalid_reg && m_axis_tready) begin
          if (beat_reg == BEAT_LAST) begin
            state_next = ACCEPT;
            beat_next  = '0;
          end else begin
            beat_next = beat_reg + 4'd1;
          end
        end
      end
      default: begin
        state_next = ACCEPT;
        beat_next  = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values. During EMIT the
  // window is frozen, so the beat is selected from the upcoming window.
  // That makes beat 0 valid on the cycle right after the completing accept.
  always_comb begin
    m_tvalid_next = (state_next == EMIT);
    m_tdata_next  = '0;
    m_tuser_next  = 1'b0;
    m_tlast_next  = 1'b0;
    if (state_next == EMIT) begin
      m_tdata_next = win_next[beat_next];
      m_tuser_next = first_next && (beat_next == 4'd0);
      m_tlast_next = (beat_next == BEAT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ACCEPT;
      x_reg        <= '0;
      y_reg        <= '0;
      beat_reg     <= '0;
      first_reg    <= 1'b0;
      s_tready_reg <= 1'b1;
      m_tvalid_reg <= 1'b0;
      m_tdata_reg  <= '0;
      m_tuser_reg  <= 1'b0;
      m_tlast_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      beat_reg     <= beat_next;
      first_reg    <= first_next;
      s_tready_reg <= (state_next == ACCEPT);
      m_tvalid_reg <= m_tvalid_next;
      m_tdata_reg  <= m_tdata_next;
      m_tuser_reg  <= m_tuser_next;
      m_tlast_reg  <= m_tlast_next;
    end
  end

  assign s_axis_tready = s_tready_reg;
  assign m_axis_tvalid = m_tvalid_reg;
  assign m_axis_tdata  = m_tdata_reg;
  assign m_axis_tuser  = m_tuser_reg;
  assign m_axis_tlast  = m_tlast_reg;

endmodule

// File: tb/tb_window_3x3_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for window_3x3_serializer: a 4x4 instance and a 5x3 instance.
// Expected windows come from a table of hand-computed window centres. Each
// window's nine beats are laid out around its centre.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_window_3x3_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [23:0] s_tdata4, m_tdata4;
  logic        s_tvalid4, s_tuser4, s_tready4;
  logic        m_tvalid4, m_tuser4, m_tlast4, m_tready4;

  logic [23:0] s_tdata5, m_tdata5;
  logic        s_tvalid5, s_tuser5, s_tready5;
  logic        m_tvalid5, m_tuser5, m_tlast5, m_tready5;

  window_3x3_serializer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(24)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata4), .s_axis_tvalid(s_tvalid4), .s_axis_tuser(s_tuser4),
    .s_axis_tready(s_tready4),
    .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tuser(m_tuser4),
    .m_axis_tlast(m_tlast4), .m_axis_tready(m_tready4)
  );

  window_3x3_serializer #(.IMG_WIDTH(5), .IMG_HEIGHT(3), .DATA_W(24)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata5), .s_axis_tvalid(s_tvalid5), .s_axis_tuser(s_tuser5),
    .s_axis_tready(s_tready5),
    .m_axis_tdata(m_tdata5), .m_axis_tvalid(m_tvalid5), .m_axis_tuser(m_tuser5),
    .m_axis_tlast(m_tlast5), .m_axis_tready(m_tready5)
  );

  typedef struct packed {
    logic [23:0] data;
    logic        user;
    logic        last;
  } beat_t;

  // One record per window: hand-computed centre pixel {y,x} and tuser flag.
  typedef struct {
    logic [15:0] centre;
    logic        first;
  } win_vec_t;

  win_vec_t vec4 [4];
  win_vec_t vec5 [3];

  beat_t q4[$], q5[$], exp_q[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  bp_mode  = 1'b0;
  bit  abort    = 1'b0;

  // Monitor bookkeeping (written only by the monitor processes).
  int    stall_errs    = 0;
  int    emit_rdy_errs = 0;
  int    stall_cnt     = 0;
  bit    hold_pend     = 1'b0;
  beat_t hold_b;

  // Downstream ready: always 1, or pseudo-random when bp_mode is set.
  initial begin
    m_tready4 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready4 = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial m_tready5 = 1'b1;

  // Monitor for the 4x4 instance: records handshaken beats. It also tracks
  // whether stalled beats stay stable and whether s_tready stays low during
  // EMIT.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend && !(m_tvalid4 && m_tdata4 == hold_b.data &&
                           m_tuser4 == hold_b.user && m_tlast4 == hold_b.last))
          stall_errs++;
        if (m_tvalid4 && s_tready4) emit_rdy_errs++;
        if (m_tvalid4 && !m_tready4) stall_cnt++;
        if (m_tvalid4 && m_tready4) q4.push_back({m_tdata4, m_tuser4, m_tlast4});
        hold_pend = m_tvalid4 && !m_tready4;
        hold_b    = {m_tdata4, m_tuser4, m_tlast4};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_tvalid5 && m_tready5) q5.push_back({m_tdata5, m_tuser5, m_tlast5});
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Nine expected beats laid out around the given centre.
  task automatic add_window(input logic [7:0] tag, input logic [15:0] centre, input logic first);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        beat_t b;
        b.data = {tag, 16'(int'(centre) + (r - 1) * 256 + (c - 1))};
        b.user = first && (r == 0) && (c == 0);
        b.last = (r == 2) && (c == 2);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic check_stream(input string name, input beat_t got[$]);
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d, required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s beat %0d: got data=%h user=%b last=%b, required data=%h user=%b last=%b",
                 name, i, got[i].data, got[i].user, got[i].last,
                 exp_q[i].data, exp_q[i].user, exp_q[i].last);
      end
      if (i % 9 == 8)
        $display("%s window %0d: centre=%h first_beat=%h", name, i / 9, got[i-4].data, got[i-8].data);
    end
  endtask

  // Present one pixel and hold it until accepted; returns at posedge+1.
  task automatic send_pix(input bit sel, input logic [23:0] d, input logic u);
    int n = 0;
    if (!sel) begin s_tdata4 = d; s_tvalid4 = 1'b1; s_tuser4 = u; end
    else      begin s_tdata5 = d; s_tvalid5 = 1'b1; s_tuser5 = u; end
    @(negedge clk);
    while (!(sel ? s_tready5 : s_tready4) && n < 400 && !abort) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got s_tready=0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    if (!sel) begin s_tvalid4 = 1'b0; s_tuser4 = 1'b0; end
    else      begin s_tvalid5 = 1'b0; s_tuser5 = 1'b0; end
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] tag, input int w, input int h, input int gap);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (abort) return;
        send_pix(sel, {tag, 8'(y), 8'(x)}, (x == 0) && (y == 0));
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic wait_beats(input bit sel, input int n, input int limit);
    int c = 0;
    while ((sel ? q5.size() : q4.size()) < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    repeat (20) @(negedge clk);
  endtask

  bit v_after, r_after, saw_trigger;

  initial begin
    vec4[0] = '{16'h0101, 1'b1};
    vec4[1] = '{16'h0102, 1'b0};
    vec4[2] = '{16'h0201, 1'b0};
    vec4[3] = '{16'h0202, 1'b0};
    vec5[0] = '{16'h0101, 1'b1};
    vec5[1] = '{16'h0102, 1'b0};
    vec5[2] = '{16'h0103, 1'b0};

    s_tdata4 = '0; s_tvalid4 = 1'b0; s_tuser4 = 1'b0;
    s_tdata5 = '0; s_tvalid5 = 1'b0; s_tuser5 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_tready", s_tready4, 1);
    chk("reset_m_tvalid", m_tvalid4, 0);
    chk("reset_m_tdata",  m_tdata4,  0);
    chk("reset_m_tuser",  m_tuser4,  0);
    chk("reset_m_tlast",  m_tlast4,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: plain 4x4 frame, no backpressure.
    q4.delete(); exp_q.delete();
    foreach (vec4[i]) add_window(8'h00, vec4[i].centre, vec4[i].first);
    send_frame(1'b0, 8'h00, 4, 4, 0);
    wait_beats(1'b0, 36, 500);
    check_stream("t1", q4);
    chk("t1_w4_centre", (q4.size() >= 36) ? 32'(q4[31].data) : 32'hdead, 32'h000202);

    // 2: same frame with random backpressure.
    q4.delete();
    bp_mode = 1'b1;
    send_frame(1'b0, 8'h00, 4, 4, 0);
    wait_beats(1'b0, 36, 3000);
    bp_mode = 1'b0;
    check_stream("t2", q4);
    chk("t2_hold_stable_errs", stall_errs, 0);
    chk("t2_stalls_seen", stall_cnt > 0, 1);

    // 3: two back-to-back frames with distinct tags.
    q4.delete(); exp_q.delete();
    foreach (vec4[i]) add_window(8'hA1, vec4[i].centre, vec4[i].first);
    foreach (vec4[i]) add_window(8'hA2, vec4[i].centre, vec4[i].first);
    send_frame(1'b0, 8'hA1, 4, 4, 0);
    send_frame(1'b0, 8'hA2, 4, 4, 0);
    wait_beats(1'b0, 72, 1000);
    check_stream("t3", q4);
    chk("t3_f2_first_beat", (q4.size() > 36) ? 32'({q4[36].data, q4[36].user}) : 32'hdead,
        32'({24'hA20000, 1'b1}));

    // 4: SOF on pixel index 5 resyncs; only post-SOF pixels form windows.
    q4.delete(); exp_q.delete();
    foreach (vec4[i]) add_window(8'hC0, vec4[i].centre, vec4[i].first);
    send_pix(1'b0, 24'hB00000, 1'b1);
    for (int i = 1; i < 5; i++) send_pix(1'b0, 24'(24'hB00000 + i), 1'b0);
    send_frame(1'b0, 8'hC0, 4, 4, 0);
    wait_beats(1'b0, 36, 1000);
    check_stream("t4", q4);

    // 5: reset pulsed during beat 4 of window 2.
    q4.delete(); exp_q.delete();
    add_window(8'hD0, vec4[0].centre, vec4[0].first);
    add_window(8'hD0, vec4[1].centre, vec4[1].first);
    while (exp_q.size() > 14) void'(exp_q.pop_back());
    abort = 1'b0;
    saw_trigger = 1'b0;
    fork
      send_frame(1'b0, 8'hD0, 4, 4, 0);
      begin
        int n = 0;
        while (!(q4.size() == 14 && m_tvalid4) && n < 2000) begin
          @(negedge clk);
          #2;
          n++;
        end
        saw_trigger = (n < 2000);
        rst_n = 1'b0;
        #1;
        v_after = m_tvalid4;
        r_after = s_tready4;
        repeat (3) @(negedge clk);
        abort = 1'b1;
      end
    join
    chk("t5_reached_beat4_w2", saw_trigger, 1);
    chk("t5_tvalid_in_reset", v_after, 0);
    chk("t5_s_tready_in_reset", r_after, 1);
    check_stream("t5_pre", q4);
    @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_s_tready_after", s_tready4, 1);
    chk("t5_tvalid_after", m_tvalid4, 0);
    q4.delete(); exp_q.delete();
    foreach (vec4[i]) add_window(8'hE0, vec4[i].centre, vec4[i].first);
    send_frame(1'b0, 8'hE0, 4, 4, 0);
    wait_beats(1'b0, 36, 1000);
    check_stream("t5_post", q4);

    // 6: 5x3 image with one pixel every 3 cycles.
    q5.delete(); exp_q.delete();
    foreach (vec5[i]) add_window(8'h00, vec5[i].centre, vec5[i].first);
    send_frame(1'b1, 8'h00, 5, 3, 2);
    wait_beats(1'b1, 27, 1000);
    check_stream("t6", q5);

    chk("emit_s_tready_errs", emit_rdy_errs, 0);
    chk("hold_stable_errs", stall_errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running, required finished");
    $fatal(1, "timeout");
  end

endmodule
